// File: rtl/down_counter_load.sv
// down_counter_load: loadable down counter of T flip-flops with a borrow chain, terminal count and sticky done.
// Define DOWN_COUNTER_SATURATE_EN to hold at zero instead of wrapping to all-ones.
module down_counter_load #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             done
);
    logic             cnt;
    logic [WIDTH:0]   zero_below;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q_next;
    logic             done_next;
    assign cnt = en & ~load;
    assign zero_below[0] = 1'b1;
    for (genvar i = 0; i < WIDTH; i++) begin : g_borrow
        assign zero_below[i+1] = zero_below[i] & ~Q[i];
    end
    // tc is gated by rst_n so it stays low while Q is forced to zero by reset
    assign tc = cnt & rst_n & zero_below[WIDTH];
`ifdef DOWN_COUNTER_SATURATE_EN
    assign t = {WIDTH{cnt & ~zero_below[WIDTH]}} & zero_below[WIDTH-1:0];
`else
    assign t = {WIDTH{cnt}} & zero_below[WIDTH-1:0];
`endif
    always_comb begin
        q_next    = load ? D : Q ^ t;
        done_next = load ? 1'b0 : done | (cnt & (Q == WIDTH'(1)));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q    <= '0;
            done <= 1'b0;
        end else begin
            Q    <= q_next;
            done <= done_next;
        end
    end
endmodule

// File: tb/tb_down_counter_load.sv
// tb_down_counter_load: scoreboard bench for down_counter_load at WIDTH=3 and WIDTH=4.
module tb_down_counter_load;
`ifdef DOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en3 = 1'b0, load3 = 1'b0, en4 = 1'b0, load4 = 1'b0;
    logic [2:0] d3 = '0, q3;
    logic [3:0] d4 = '0, q4;
    logic       tc3, done3, tc4, done4;
    int         total = 0, bad = 0;
    int         m3 = 0, m4 = 0;
    logic       md3 = 1'b0, md4 = 1'b0, exp_tc3 = 1'b0, exp_tc4 = 1'b0;
    logic [3:0] sb3[$];
    logic [4:0] sb4[$];
    logic [3:0] e3;
    logic [4:0] e4;

    down_counter_load #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .en(en3), .load(load3), .D(d3), .Q(q3), .tc(tc3), .done(done3));
    down_counter_load #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .en(en4), .load(load4), .D(d4), .Q(q4), .tc(tc4), .done(done4));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply3(input logic e, input logic l, input logic [2:0] d);
        en3 = e; load3 = l; d3 = d;
        exp_tc3 = e & ~l & (m3 == 0);
        if (l) begin
            m3 = int'(d); md3 = 1'b0;
        end else if (e) begin
            if (m3 == 1) md3 = 1'b1;
            m3 = (m3 == 0) ? (SAT ? 0 : 7) : m3 - 1;
        end
        sb3.push_back({md3, 3'(m3)});
    endtask

    task automatic apply4(input logic e, input logic l, input logic [3:0] d);
        en4 = e; load4 = l; d4 = d;
        exp_tc4 = e & ~l & (m4 == 0);
        if (l) begin
            m4 = int'(d); md4 = 1'b0;
        end else if (e) begin
            if (m4 == 1) md4 = 1'b1;
            m4 = (m4 == 0) ? (SAT ? 0 : 15) : m4 - 1;
        end
        sb4.push_back({md4, 4'(m4)});
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({done3, q3, tc3} !== 5'b0) begin bad++; $display("FAIL reset_init: got done=%b q=%0d tc=%b want 0 0 0", done3, q3, tc3); end
        @(negedge clk); rst_n = 1'b1;
        apply3(1'b0, 1'b1, 3'd6); tick;
        e3 = sb3.pop_front();
        total++;
        if ({done3, q3} !== e3) begin bad++; $display("FAIL reset_load6: got done=%b q=%0d want %b %0d", done3, q3, e3[3], e3[2:0]); end
        apply3(1'b1, 1'b0, 3'd0); tick;
        e3 = sb3.pop_front();
        total++;
        if ({done3, q3} !== e3 || q3 !== 3'd5) begin bad++; $display("FAIL reset_count5: got done=%b q=%0d want %b %0d", done3, q3, e3[3], e3[2:0]); end
        #2 rst_n = 1'b0;
        m3 = 0; md3 = 1'b0;
        #1;
        total++;
        if ({done3, q3, tc3} !== 5'b0) begin bad++; $display("FAIL reset_async: got done=%b q=%0d tc=%b want 0 0 0", done3, q3, tc3); end
        en3 = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        apply3(1'b0, 1'b0, 3'd3); tick;
        e3 = sb3.pop_front();
        total++;
        if ({done3, q3} !== e3) begin bad++; $display("FAIL reset_release: got done=%b q=%0d want %b %0d", done3, q3, e3[3], e3[2:0]); end
    endtask

    task automatic test_load_count;
        apply3(1'b0, 1'b1, 3'd3); tick;
        e3 = sb3.pop_front();
        total++;
        if ({done3, q3} !== e3 || q3 !== 3'd3) begin bad++; $display("FAIL load3: got done=%b q=%0d want %b %0d", done3, q3, e3[3], e3[2:0]); end
        for (int k = 0; k < 3; k++) begin
            apply3(1'b1, 1'b0, 3'd0); #1;
            total++;
            if (tc3 !== exp_tc3) begin bad++; $display("FAIL count_tc%0d: got %b want %b", k, tc3, exp_tc3); end
            tick;
            e3 = sb3.pop_front();
            total++;
            if ({done3, q3} !== e3) begin bad++; $display("FAIL count_q%0d: got done=%b q=%0d want %b %0d", k, done3, q3, e3[3], e3[2:0]); end
        end
    endtask

    task automatic test_wrap;
        apply3(1'b1, 1'b0, 3'd0); #1;
        total++;
        if (tc3 !== 1'b1) begin bad++; $display("FAIL wrap_tc: got %b want 1", tc3); end
        tick;
        e3 = sb3.pop_front();
        total++;
        if ({done3, q3} !== e3 || done3 !== 1'b1) begin bad++; $display("FAIL wrap_q: got done=%b q=%0d want %b %0d", done3, q3, e3[3], e3[2:0]); end
        apply3(1'b1, 1'b0, 3'd0); tick;
        e3 = sb3.pop_front();
        total++;
        if ({done3, q3} !== e3) begin bad++; $display("FAIL wrap_next: got done=%b q=%0d want %b %0d", done3, q3, e3[3], e3[2:0]); end
    endtask

    task automatic test_priority;
        apply3(1'b0, 1'b1, 3'd4); tick;
        e3 = sb3.pop_front();
        apply3(1'b1, 1'b1, 3'd6); #1;
        total++;
        if (tc3 !== 1'b0) begin bad++; $display("FAIL prio_tc: got %b want 0", tc3); end
        tick;
        e3 = sb3.pop_front();
        total++;
        if ({done3, q3} !== e3 || q3 !== 3'd6) begin bad++; $display("FAIL prio_q: got done=%b q=%0d want %b %0d", done3, q3, e3[3], e3[2:0]); end
    endtask

    task automatic test_hold_load_zero;
        apply3(1'b0, 1'b1, 3'd2); tick;
        e3 = sb3.pop_front();
        for (int k = 0; k < 5; k++) begin
            apply3(1'b0, 1'b0, 3'd5); tick;
            e3 = sb3.pop_front();
            total++;
            if ({done3, q3} !== e3 || q3 !== 3'd2) begin bad++; $display("FAIL hold%0d: got done=%b q=%0d want %b %0d", k, done3, q3, e3[3], e3[2:0]); end
        end
        apply3(1'b1, 1'b0, 3'd0); tick;
        e3 = sb3.pop_front();
        apply3(1'b1, 1'b0, 3'd0); tick;
        e3 = sb3.pop_front();
        apply3(1'b0, 1'b1, 3'd0); tick;
        e3 = sb3.pop_front();
        total++;
        if ({done3, q3} !== e3 || {done3, q3} !== 4'b0) begin bad++; $display("FAIL load_zero: got done=%b q=%0d want %b %0d", done3, q3, e3[3], e3[2:0]); end
        apply3(1'b0, 1'b0, 3'd0); tick;
        e3 = sb3.pop_front();
        total++;
        if ({done3, q3} !== e3) begin bad++; $display("FAIL load_zero_hold: got done=%b q=%0d want %b %0d", done3, q3, e3[3], e3[2:0]); end
    endtask

    task automatic test_full_cycle4;
        int pulses = 0;
        apply4(1'b0, 1'b1, 4'd15); tick;
        e4 = sb4.pop_front();
        total++;
        if ({done4, q4} !== e4) begin bad++; $display("FAIL full_load: got done=%b q=%0d want %b %0d", done4, q4, e4[4], e4[3:0]); end
        for (int k = 0; k < 16; k++) begin
            apply4(1'b1, 1'b0, 4'd0); #1;
            if (tc4 === 1'b1) pulses++;
            total++;
            if (tc4 !== exp_tc4) begin bad++; $display("FAIL full_tc%0d: got %b want %b", k, tc4, exp_tc4); end
            tick;
            e4 = sb4.pop_front();
            total++;
            if ({done4, q4} !== e4) begin bad++; $display("FAIL full_q%0d: got done=%b q=%0d want %b %0d", k, done4, q4, e4[4], e4[3:0]); end
        end
        en4 = 1'b0;
        total++;
        if (pulses != 1) begin bad++; $display("FAIL full_tc_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 40; k++) begin
            apply3(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7))); #1;
            total++;
            if (tc3 !== exp_tc3) begin bad++; $display("FAIL b2b_tc%0d: got %b want %b", k, tc3, exp_tc3); end
            tick;
            e3 = sb3.pop_front();
            total++;
            if ({done3, q3} !== e3) begin bad++; $display("FAIL b2b_q%0d: got done=%b q=%0d want %b %0d", k, done3, q3, e3[3], e3[2:0]); end
        end
    endtask

    initial begin
        test_reset;
        test_load_count;
        test_wrap;
        test_priority;
        test_hold_load_zero;
        test_full_cycle4;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
